bist_and_ctrl: RTL and testbench

- Self-contained built-in self-test wrapper around a 2-input AND gate, which is the circuit under test (CUT).
- Two seedable XNOR LFSRs generate the CUT operands. A 3-bit signature register compacts the CUT output.
- After a fixed pattern count, the signature is compared with a supplied golden value and the result is reported on pass_fail.
- Sits beside the functional logic and is triggered by a one-cycle start pulse from the test controller.

---
 rtl/bist_and_pkg.sv | 20 ++
 rtl/bist_and_ctrl_if.sv | 32 +++
 rtl/bist_lfsr.sv | 46 ++++
 rtl/bist_and_ctrl.sv | 116 +++++++++++
 tb/tb_bist_and_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/bist_and_pkg.sv
// Shared types and constants for the AND-gate BIST wrapper.
package bist_and_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } bist_state_e;

    localparam int LFSR_A_W     = 3;
    localparam int LFSR_B_W     = 2;
    localparam int SIG_W        = 3;
    localparam int TEST_LEN_DEF = 8;

    // Feedback taps: A uses a[2]^a[1], B uses b[1]^b[0] (both inverted)
    localparam logic [LFSR_A_W-1:0] LFSR_A_TAPS = 3'b110;
    localparam logic [LFSR_B_W-1:0] LFSR_B_TAPS = 2'b11;

endpackage

// File: rtl/bist_and_ctrl_if.sv
// Control/result bundle between the test controller and the BIST wrapper.
// The fault_inject signal exists only when BIST_FAULT_INJECT_EN is defined.
interface bist_and_ctrl_if;
    import bist_and_pkg::*;

    logic                Start_BIST;
    logic [LFSR_A_W-1:0] seed1;
    logic [LFSR_B_W-1:0] seed2;
    logic [SIG_W-1:0]    golden_sig;
    logic                pass_fail;
    logic                bist_done;
`ifdef BIST_FAULT_INJECT_EN
    logic                fault_inject;
`endif

    modport master (
`ifdef BIST_FAULT_INJECT_EN
        output fault_inject,
`endif
        output Start_BIST, seed1, seed2, golden_sig,
        input  pass_fail, bist_done
    );

    modport slave (
`ifdef BIST_FAULT_INJECT_EN
        input  fault_inject,
`endif
        input  Start_BIST, seed1, seed2, golden_sig,
        output pass_fail, bist_done
    );

endinterface

// File: rtl/bist_lfsr.sv
// Seedable shift-left XNOR LFSR; load has priority over enable.
module bist_lfsr #(
    parameter int               WIDTH    = 3,
    parameter logic [WIDTH-1:0] TAP_MASK = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] shifted;

    // XNOR feedback keeps all-zero inside the sequence; all-ones locks up
    assign shifted[0] = ~^(lfsr_q & TAP_MASK);

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign shifted[gi] = lfsr_q[gi-1];
        end
    endgenerate

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (en) begin
            lfsr_d = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/bist_and_ctrl.sv
// BIST wrapper: two LFSRs drive a 2-input AND, a 3-bit signature compacts it.
// Optional stuck-at-0 injection on the CUT output with BIST_FAULT_INJECT_EN.
module bist_and_ctrl
    import bist_and_pkg::*;
#(
    parameter  int TEST_LEN = TEST_LEN_DEF,
    localparam int CNT_W    = $clog2(TEST_LEN + 1)
) (
    input  logic           clk,
    input  logic           rst,
    bist_and_ctrl_if.slave bus
);

    bist_state_e         state_q, state_d;
    logic [SIG_W-1:0]    sig_q, sig_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pass_fail_q, pass_fail_d;
    logic                bist_done_q, bist_done_d;

    logic                lfsr_load;
    logic                lfsr_en;
    logic [LFSR_A_W-1:0] a_val;
    logic [LFSR_B_W-1:0] b_val;
    logic                fault_active;
    logic                cut_y;

    bist_lfsr #(
        .WIDTH    (LFSR_A_W),
        .TAP_MASK (LFSR_A_TAPS)
    ) u_lfsr_a (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .en   (lfsr_en),
        .seed (bus.seed1),
        .q    (a_val)
    );

    bist_lfsr #(
        .WIDTH    (LFSR_B_W),
        .TAP_MASK (LFSR_B_TAPS)
    ) u_lfsr_b (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .en   (lfsr_en),
        .seed (bus.seed2),
        .q    (b_val)
    );

`ifdef BIST_FAULT_INJECT_EN
    assign fault_active = bus.fault_inject && (state_q == RUN);
`else
    assign fault_active = 1'b0;
`endif

    assign cut_y = a_val[0] & b_val[0] & ~fault_active;

    always_comb begin
        state_d     = state_q;
        sig_d       = sig_q;
        cnt_d       = cnt_q;
        pass_fail_d = pass_fail_q;
        bist_done_d = bist_done_q;
        lfsr_load   = 1'b0;
        lfsr_en     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.Start_BIST) begin
                    lfsr_load   = 1'b1;
                    sig_d       = '0;
                    cnt_d       = '0;
                    pass_fail_d = 1'b0;
                    bist_done_d = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                sig_d   = {sig_q[1], sig_q[0] ^ sig_q[2], sig_q[2] ^ cut_y};
                lfsr_en = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                // Counter value here is the index of the pattern being applied
                if (cnt_q == CNT_W'(TEST_LEN - 1)) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                pass_fail_d = (sig_q == bus.golden_sig);
                bist_done_d = 1'b1;
                state_d     = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sig_q       <= '0;
            cnt_q       <= '0;
            pass_fail_q <= 1'b0;
            bist_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sig_q       <= sig_d;
            cnt_q       <= cnt_d;
            pass_fail_q <= pass_fail_d;
            bist_done_q <= bist_done_d;
        end
    end

    assign bus.pass_fail = pass_fail_q;
    assign bus.bist_done = bist_done_q;

endmodule

// File: tb/tb_bist_and_ctrl.sv
// Directed self-checking bench for bist_and_ctrl (TEST_LEN = 8).
module tb_bist_and_ctrl;
    import bist_and_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    bist_and_ctrl_if bus ();

    bist_and_ctrl #(.TEST_LEN(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Drives a one-cycle start; returns at the negedge just after the start edge E0
    task automatic start_pulse(input logic [2:0] s1, input logic [1:0] s2, input logic [2:0] gold);
        @(negedge clk);
        bus.seed1      = s1;
        bus.seed2      = s2;
        bus.golden_sig = gold;
        bus.Start_BIST = 1'b1;
        @(negedge clk);
        bus.Start_BIST = 1'b0;
        $display("start seed1=%0d seed2=%0d golden=%0d", s1, s2, gold);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.pass_fail !== 1'b0) $display("FAIL reset_pass_fail got=%b exp=0", bus.pass_fail);
        else passed++;
        checks++;
        if (bus.bist_done !== 1'b0) $display("FAIL reset_bist_done got=%b exp=0", bus.bist_done);
        else passed++;
        checks++;
        if (dut.state_q !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE);
        else passed++;
        repeat (5) @(negedge clk);
        checks++;
        if (dut.state_q !== IDLE || bus.bist_done !== 1'b0)
            $display("FAIL reset_idle_hold state=%0d done=%b exp state=0 done=0", dut.state_q, bus.bist_done);
        else passed++;
        $display("reset done pass_fail=%b bist_done=%b", bus.pass_fail, bus.bist_done);
    endtask

    task automatic test_golden_pass();
        start_pulse(3'd0, 2'd0, 3'd6);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (bus.bist_done !== 1'b0) $display("FAIL pass_early_done E%0d got=%b exp=0", k, bus.bist_done);
            else passed++;
        end
        @(negedge clk);
        checks++;
        if (dut.sig_q !== 3'b110) $display("FAIL pass_signature got=%b exp=110", dut.sig_q);
        else passed++;
        checks++;
        if (bus.bist_done !== 1'b1) $display("FAIL pass_done_E9 got=%b exp=1", bus.bist_done);
        else passed++;
        checks++;
        if (bus.pass_fail !== 1'b1) $display("FAIL pass_result got=%b exp=1", bus.pass_fail);
        else passed++;
        $display("golden pass run: done=%b pass_fail=%b sig=%b", bus.bist_done, bus.pass_fail, dut.sig_q);
    endtask

    task automatic test_golden_fail();
        start_pulse(3'd0, 2'd0, 3'd2);
        repeat (8) @(negedge clk);
        checks++;
        if (bus.bist_done !== 1'b0) $display("FAIL fail_early_done got=%b exp=0", bus.bist_done);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.bist_done !== 1'b1) $display("FAIL fail_done_E9 got=%b exp=1", bus.bist_done);
        else passed++;
        checks++;
        if (bus.pass_fail !== 1'b0) $display("FAIL fail_result got=%b exp=0", bus.pass_fail);
        else passed++;
        $display("golden fail run: done=%b pass_fail=%b", bus.bist_done, bus.pass_fail);
    endtask

    task automatic test_ignored_start();
        start_pulse(3'd0, 2'd0, 3'd6);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus.Start_BIST = (k == 3);
        end
        checks++;
        if (bus.bist_done !== 1'b0) $display("FAIL ignored_early_done got=%b exp=0", bus.bist_done);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.bist_done !== 1'b1 || bus.pass_fail !== 1'b1)
            $display("FAIL ignored_result done=%b pass_fail=%b exp done=1 pass_fail=1", bus.bist_done, bus.pass_fail);
        else passed++;
        $display("ignored start run: done=%b pass_fail=%b", bus.bist_done, bus.pass_fail);
    endtask

    task automatic test_restart();
        start_pulse(3'd0, 2'd0, 3'd6);
        checks++;
        if (bus.bist_done !== 1'b0 || bus.pass_fail !== 1'b0)
            $display("FAIL restart_clear done=%b pass_fail=%b exp 0 0", bus.bist_done, bus.pass_fail);
        else passed++;
        repeat (8) @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.bist_done !== 1'b1 || bus.pass_fail !== 1'b1)
            $display("FAIL restart_result done=%b pass_fail=%b exp done=1 pass_fail=1", bus.bist_done, bus.pass_fail);
        else passed++;
        $display("restart run: done=%b pass_fail=%b", bus.bist_done, bus.pass_fail);
    endtask

    task automatic test_reset_mid_run();
        bit rose = 1'b0;
        start_pulse(3'd0, 2'd0, 3'd6);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (dut.state_q !== IDLE || bus.bist_done !== 1'b0 || bus.pass_fail !== 1'b0)
            $display("FAIL midrun_reset state=%0d done=%b pass_fail=%b exp 0 0 0",
                     dut.state_q, bus.bist_done, bus.pass_fail);
        else passed++;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.bist_done !== 1'b0) rose = 1'b1;
        end
        checks++;
        if (rose !== 1'b0) $display("FAIL midrun_done_rose got=%b exp=0", rose);
        else passed++;
        $display("reset mid-run: state=%0d done=%b", dut.state_q, bus.bist_done);
    endtask

    // LFSR A locked at 111 gives y = b[0] = 0,1,0,0,1,0,0,1 -> signature 111
    task automatic test_seed_lock();
        start_pulse(3'b111, 2'd0, 3'd7);
        repeat (9) @(negedge clk);
        checks++;
        if (dut.sig_q !== 3'b111) $display("FAIL lock_signature got=%b exp=111", dut.sig_q);
        else passed++;
        checks++;
        if (bus.bist_done !== 1'b1 || bus.pass_fail !== 1'b1)
            $display("FAIL lock_result done=%b pass_fail=%b exp 1 1", bus.bist_done, bus.pass_fail);
        else passed++;
        $display("seed lock run: sig=%b pass_fail=%b", dut.sig_q, bus.pass_fail);
    endtask

`ifdef BIST_FAULT_INJECT_EN
    task automatic test_fault_inject();
        bus.fault_inject = 1'b1;
        start_pulse(3'd0, 2'd0, 3'd6);
        repeat (9) @(negedge clk);
        checks++;
        if (dut.sig_q !== 3'b000) $display("FAIL fault_signature got=%b exp=000", dut.sig_q);
        else passed++;
        checks++;
        if (bus.bist_done !== 1'b1 || bus.pass_fail !== 1'b0)
            $display("FAIL fault_detect done=%b pass_fail=%b exp 1 0", bus.bist_done, bus.pass_fail);
        else passed++;
        start_pulse(3'd0, 2'd0, 3'd0);
        repeat (9) @(negedge clk);
        checks++;
        if (bus.bist_done !== 1'b1 || bus.pass_fail !== 1'b1)
            $display("FAIL fault_zero_golden done=%b pass_fail=%b exp 1 1", bus.bist_done, bus.pass_fail);
        else passed++;
        bus.fault_inject = 1'b0;
        $display("fault inject runs: sig=%b pass_fail=%b", dut.sig_q, bus.pass_fail);
    endtask
`endif

    initial begin
        rst            = 1'b1;
        bus.Start_BIST = 1'b0;
        bus.seed1      = '0;
        bus.seed2      = '0;
        bus.golden_sig = '0;
`ifdef BIST_FAULT_INJECT_EN
        bus.fault_inject = 1'b0;
`endif
        test_reset();
        test_golden_pass();
        test_golden_fail();
        test_ignored_start();
        test_restart();
        test_reset_mid_run();
        test_seed_lock();
`ifdef BIST_FAULT_INJECT_EN
        test_fault_inject();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
